// File: rtl/sram_port_arbiter.sv
`default_nettype none
// =============================================================================
// sram_port_arbiter: two-port SRAM access arbiter, port 0 priority by default;
// ARB_STARVE_GUARD_EN adds a port-1 starvation guard.  Rev 1.0
// =============================================================================
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_p0_req,
  input  logic             i_p0_we,
  input  logic [3:0]       i_p0_be,
  input  logic [31:0]      i_p0_addr,
  input  logic [31:0]      i_p0_wdata,
  input  logic             i_p1_req,
  input  logic             i_p1_we,
  input  logic [3:0]       i_p1_be,
  input  logic [31:0]      i_p1_addr,
  input  logic [31:0]      i_p1_wdata,
  output logic             o_p0_gnt,
  output logic             o_p1_gnt,
  output logic             o_p0_rvalid,
  output logic             o_p1_rvalid,
  output logic [31:0]      o_p0_rdata,
  output logic [31:0]      o_p1_rdata,
  output logic             o_sram_cen,
  output logic             o_sram_wen,
  output logic [3:0]       o_sram_ben,
  output logic [31:0]      o_sram_addr,
  output logic [31:0]      o_sram_din,
  input  logic [31:0]      i_sram_dout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_P0   = 2'd1,
    RSP_P1   = 2'd2
  } rsp_e;

  rsp_e             r_rsp;
  rsp_e             w_rsp_nxt;
  logic             r_active;
  logic             w_gnt_en;
  logic             w_force_p1;
  logic             w_p0_stall;
  logic [CNT_W-1:0] r_stall;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_limit_check
    $error("STARVE_LIMIT must lie in 1..15");
  end

  // Grants stay off while in reset and for the first cycle after it.
  always_ff @(posedge clk) begin
    r_active <= rst_n;
  end

  assign w_gnt_en = rst_n & r_active;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;

  assign w_force_p1 = i_p1_req & (r_starve == c_starve_limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (!i_p1_req || o_p1_gnt) begin
      r_starve <= 4'd0;
    end else if (r_starve != c_starve_limit) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_force_p1 = 1'b0;
`endif

  always_comb begin
    o_p0_gnt = 1'b0;
    o_p1_gnt = 1'b0;
    if (w_gnt_en) begin
      if (w_force_p1) begin
        o_p1_gnt = 1'b1;
      end else if (i_p0_req) begin
        o_p0_gnt = 1'b1;
      end else if (i_p1_req) begin
        o_p1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    o_sram_cen  = 1'b1;
    o_sram_wen  = 1'b1;
    o_sram_ben  = 4'hF;
    o_sram_addr = 32'd0;
    o_sram_din  = 32'd0;
    if (o_p0_gnt) begin
      o_sram_cen  = 1'b0;
      o_sram_wen  = ~i_p0_we;
      o_sram_ben  = ~i_p0_be;
      o_sram_addr = i_p0_addr;
      o_sram_din  = i_p0_wdata;
    end else if (o_p1_gnt) begin
      o_sram_cen  = 1'b0;
      o_sram_wen  = ~i_p1_we;
      o_sram_ben  = ~i_p1_be;
      o_sram_addr = i_p1_addr;
      o_sram_din  = i_p1_wdata;
    end
  end

  // Response tag: which port owns the SRAM data appearing next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp <= RSP_NONE;
    end else begin
      r_rsp <= w_rsp_nxt;
    end
  end

  always_comb begin
    w_rsp_nxt = RSP_NONE;
    if (o_p0_gnt && !i_p0_we) begin
      w_rsp_nxt = RSP_P0;
    end else if (o_p1_gnt && !i_p1_we) begin
      w_rsp_nxt = RSP_P1;
    end
  end

  assign o_p0_rvalid = rst_n & (r_rsp == RSP_P0);
  assign o_p1_rvalid = rst_n & (r_rsp == RSP_P1);
  assign o_p0_rdata  = o_p0_rvalid ? i_sram_dout : 32'd0;
  assign o_p1_rdata  = o_p1_rvalid ? i_sram_dout : 32'd0;

  assign w_p0_stall = i_p0_req & ~o_p0_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_p0_stall && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// =============================================================================
// tb_sram_port_arbiter: scoreboard bench with a behavioural arbiter/SRAM model.
// =============================================================================
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;
  localparam int CW    = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [3:0]  p0_be = 4'h0, p1_be = 4'h0;
  logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sram_cen, sram_wen;
  logic [3:0]  sram_ben;
  logic [31:0] sram_addr, sram_din;
  logic [31:0] sram_dout;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_be(p0_be), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_be(p1_be), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p0_gnt(p0_gnt), .o_p1_gnt(p1_gnt), .o_p0_rvalid(p0_rvalid), .o_p1_rvalid(p1_rvalid),
    .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata),
    .o_sram_cen(sram_cen), .o_sram_wen(sram_wen), .o_sram_ben(sram_ben),
    .o_sram_addr(sram_addr), .o_sram_din(sram_din), .i_sram_dout(sram_dout),
    .o_stall_cnt(stall_cnt)
  );

  // Behavioural SRAM driven by the DUT pins (registered read data).
  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem  [256];

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr[9:2]];
      end
    end
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   done    = 1'b0;

  // Model state
  int          m_starve = 0;
  logic [31:0] m_stall  = '0;
  bit          m_first  = 1'b0;
  bit          m_known  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [3:0] b0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [3:0] b1,
                      input logic [31:0] a1, input logic [31:0] d1);
    int          eg;
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] ea, ed;
    @(posedge clk);
    #1;
    rst_n = rst;
    p0_req = r0; p0_we = w0; p0_be = b0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_be = b1; p1_addr = a1; p1_wdata = d1;
    if (!rst) exp_q.delete();
    #3;
    if (!rst || m_first)                       eg = 0;
    else if (GUARD && r1 && m_starve == LIMIT) eg = 2;
    else if (r0)                               eg = 1;
    else if (r1)                               eg = 2;
    else                                       eg = 0;
    ewe = (eg == 1) ? w0 : w1;
    ebe = (eg == 1) ? b0 : b1;
    ea  = (eg == 1) ? a0 : a1;
    ed  = (eg == 1) ? d0 : d1;
    chk("p0_gnt", 32'(p0_gnt), 32'(eg == 1));
    chk("p1_gnt", 32'(p1_gnt), 32'(eg == 2));
    if (eg == 0) begin
      chk("idle_pins", {23'd0, sram_cen, sram_wen, sram_ben, 3'd0}, {23'd0, 1'b1, 1'b1, 4'hF, 3'd0});
      chk("idle_addr", sram_addr, 32'd0);
      chk("idle_din", sram_din, 32'd0);
    end else begin
      chk("gnt_pins", {23'd0, sram_cen, sram_wen, sram_ben, 3'd0}, {23'd0, 1'b0, ~ewe, ~ebe, 3'd0});
      chk("gnt_addr", sram_addr, ea);
      chk("gnt_din", sram_din, ed);
    end
    if (m_known) chk("stall_cnt", 32'(stall_cnt), m_stall);
    if (!rst) begin
      m_starve = 0; m_stall = '0; m_first = 1'b1; m_known = 1'b1;
    end else begin
      m_first = 1'b0;
      if (r0 && eg != 1 && m_stall < (2**CW - 1)) m_stall = m_stall + 1;
      if (!r1 || eg == 2)      m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (eg != 0) begin
        if (ewe) begin
          for (int b = 0; b < 4; b++)
            if (ebe[b]) ref_mem[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
        end else begin
          exp_q.push_back('{port: eg - 1, data: ref_mem[ea[9:2]], due: cyc + 1});
        end
      end
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  task automatic rd(input int port, input logic [31:0] a);
    if (port == 0) step(1'b1, 1'b1, 1'b0, 4'hF, a, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    else           step(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0, 4'hF, a, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin
    rsp_t e;
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_missing: port %0d data %h due cycle %0d never returned", exp_q[0].port, exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (p0_rvalid || p1_rvalid) begin
        chk("rvalid_onehot", 32'(p0_rvalid & p1_rvalid), 32'd0);
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected (cycle %0d): rvalid p0=%0b p1=%0b with no read due", cyc, p0_rvalid, p1_rvalid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_port", 32'(p1_rvalid), 32'(e.port));
          chk("rsp_data", (e.port == 1) ? p1_rdata : p0_rdata, e.data);
          chk("rsp_other_rdata", (e.port == 1) ? p0_rdata : p1_rdata, 32'd0);
        end
      end else begin
        chk("rdata_idle", p0_rdata | p1_rdata, 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1;
    logic prev_rst;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[8'h04] = 32'hDEADBEEF;
    ref_mem[8'h04]  = 32'hDEADBEEF;

    // Reset with both ports requesting: no grants, idle pins.
    repeat (3) step(1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'd0, 1'b1, 1'b1, 4'hF, 32'h44, 32'h1);
    idle(1'b1);

    // Single p0 read of 0x10
    rd(0, 32'h10);
    idle(1'b1);
    chk("dir_deadbeef", p0_rdata, 32'hDEADBEEF);

    // p1 partial write then p0 read-back
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h0000ABCD);
    rd(0, 32'h20);
    idle(1'b1);
    chk("dir_halfword", {16'd0, p0_rdata[15:0]}, 32'h0000ABCD);

    // Alternating back-to-back reads
    rd(0, 32'h0);
    rd(1, 32'h4);
    rd(0, 32'h8);
    idle(1'b1);
    idle(1'b1);

    // Read granted, then reset on the following edge
    rd(0, 32'h10);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);

    // Both ports requesting for 10 cycles
    g0 = 0; g1 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'hF, 32'(i * 8), 32'd0, 1'b1, 1'b0, 4'hF, 32'(i * 8 + 4), 32'd0);
      g0 += int'(p0_gnt);
      g1 += int'(p1_gnt);
    end
    idle(1'b1);
    chk("contend_p0_grants", 32'(g0), GUARD ? 32'd8 : 32'd10);
    chk("contend_p1_grants", 32'(g1), GUARD ? 32'd2 : 32'd0);
    chk("contend_stall", 32'(stall_cnt), GUARD ? 32'd2 : 32'd0);

    // Randomized traffic with occasional resets
    prev_rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!prev_rst) begin
        idle(1'b1);
        prev_rst = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        step(1'b0, $urandom_range(0, 1) == 1, 1'b0, 4'hF, $urandom, 32'd0,
             1'b1, 1'b0, 4'hF, $urandom, 32'd0);
        prev_rst = 1'b0;
      end else begin
        step(1'b1, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 4'($urandom), $urandom, $urandom,
             $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 4'($urandom), $urandom, $urandom);
      end
    end

    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
